// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS-subset constants for the fetch stage, decoder and bench
package mips_pkg;

  localparam int          INSTR_W          = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] NOP       = '0;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_J     = 6'b000010,
    OP_BEQ   = 6'b000100,
    OP_ADDIU = 6'b001001,
    OP_ORI   = 6'b001101,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - circular store of {pc, instr, filled} entries between fetch and decode
// Entries are allocated in request order and filled in the same order, so one fill pointer suffices.
module fetch_buffer
  import mips_pkg::*;
#(
  parameter int  DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               alloc_i,
  input  logic [31:0]        alloc_pc_i,
  input  logic               fill_i,
  input  logic [INSTR_W-1:0] fill_instr_i,
  input  logic               pop_i,
  input  logic               flush_i,
  output logic [CW-1:0]      count_o,
  output logic [CW-1:0]      unfilled_o,
  output logic               head_valid_o,
  output logic [31:0]        head_pc_o,
  output logic [INSTR_W-1:0] head_instr_o
);

  logic [PW-1:0]      head_q, head_d, tail_q, tail_d, fptr_q, fptr_d;
  logic [CW-1:0]      count_q, count_d, unf_q, unf_d;
  logic [DEPTH-1:0]   filled_q, filled_d;
  logic [31:0]        pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic               do_alloc, do_fill, do_pop;

  assign head_valid_o = (count_q != '0) && filled_q[head_q];
  assign head_pc_o    = pc_mem[head_q];
  assign head_instr_o = instr_mem[head_q];
  assign count_o      = count_q;
  assign unfilled_o   = unf_q;

  assign do_alloc = alloc_i && (count_q < CW'(DEPTH));
  assign do_fill  = fill_i && (unf_q != '0);
  assign do_pop   = pop_i && head_valid_o;

  always_comb begin
    head_d   = head_q;
    tail_d   = tail_q;
    fptr_d   = fptr_q;
    count_d  = count_q;
    unf_d    = unf_q;
    filled_d = filled_q;
    if (flush_i) begin
      head_d   = '0;
      tail_d   = '0;
      fptr_d   = '0;
      count_d  = '0;
      unf_d    = '0;
      filled_d = '0;
    end else begin
      if (do_alloc) tail_d = tail_q + PW'(1);
      if (do_fill) begin
        fptr_d           = fptr_q + PW'(1);
        filled_d[fptr_q] = 1'b1;
      end
      if (do_pop) begin
        head_d           = head_q + PW'(1);
        filled_d[head_q] = 1'b0;
      end
      count_d = count_q + CW'(do_alloc) - CW'(do_pop);
      unf_d   = unf_q + CW'(do_alloc) - CW'(do_fill);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q   <= '0;
      tail_q   <= '0;
      fptr_q   <= '0;
      count_q  <= '0;
      unf_q    <= '0;
      filled_q <= '0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      fptr_q   <= fptr_d;
      count_q  <= count_d;
      unf_q    <= unf_d;
      filled_q <= filled_d;
    end
  end

  // Payload needs no reset: the filled bits gate every read of it.
  always_ff @(posedge clk) begin
    if (do_alloc && !flush_i) pc_mem[tail_q] <= alloc_pc_i;
    if (do_fill && !flush_i) instr_mem[fptr_q] <= fill_instr_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - IF stage: PC, in-order instruction memory requests, redirect flush
// Responses still in flight at a redirect are counted in drop_q and discarded as they return.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [31:0]        imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               id_ready,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc_plus4
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]        pc_q, pc_d;
  logic [CW-1:0]      drop_q, drop_d, drop_sum;
  logic [CW-1:0]      count, unfilled;
  logic               head_valid;
  logic [31:0]        head_pc;
  logic [INSTR_W-1:0] head_instr;
  logic               req_accept, rsp_fill, pop;
  logic               unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign imem_req_valid = !reset && (count < CW'(DEPTH)) && !redirect_valid;
  assign imem_req_addr  = pc_q;
  assign req_accept     = imem_req_valid && imem_req_ready;
  assign rsp_fill       = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign pop            = head_valid && id_ready && !redirect_valid;

  always_comb begin
    pc_d     = pc_q;
    drop_d   = drop_q;
    drop_sum = drop_q + unfilled;
    if (redirect_valid) begin
      pc_d = {redirect_pc[31:2], 2'b00};
      // A response landing now consumes one outstanding slot, old or unfilled.
      drop_d = (imem_rsp_valid && (drop_sum != '0)) ? drop_sum - CW'(1) : drop_sum;
    end else begin
      if (req_accept) pc_d = pc_q + 32'd4;
      if (imem_rsp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk          (clk),
    .reset        (reset),
    .alloc_i      (req_accept),
    .alloc_pc_i   (pc_q),
    .fill_i       (rsp_fill),
    .fill_instr_i (imem_rsp_data),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .count_o      (count),
    .unfilled_o   (unfilled),
    .head_valid_o (head_valid),
    .head_pc_o    (head_pc),
    .head_instr_o (head_instr)
  );

  assign if_valid    = head_valid;
  assign if_instr    = head_valid ? head_instr : NOP;
  assign if_pc       = head_valid ? head_pc : 32'h0;
  assign if_pc_plus4 = head_valid ? head_pc + 32'd4 : 32'h0;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- IF stage of the pipelined MIPS-subset CPU and the producer side of the IF→ID interface.
- Holds the PC and issues in-order word fetches to instruction memory over a valid/ready request channel.
- Buffers returned instructions with their PCs and presents them one per cycle to the ID-stage opcode decoder under a valid/ready handshake.
- Accepts branch/jump redirects from the pipeline and discards all wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_3000, PC loaded on reset; bits [1:0] must be 0
DEPTH, 2, fetch buffer entries; power of two, range 2..8

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word address of request (= PC)
imem_rsp_valid  input  1  instruction word returned; in order, ≥1 cycle after acceptance
imem_rsp_data  input  32  returned instruction
redirect_valid  input  1  branch taken / jump; flush and refetch
redirect_pc  input  32  new PC; bits [1:0] ignored (forced 00)
id_ready  input  1  ID stage accepts instruction (low = hazard stall)
if_valid  output  1  if_instr/if_pc valid to ID
if_instr  output  32  instruction to decoder (op = [31:26])
if_pc  output  32  PC of if_instr
if_pc_plus4  output  32  if_pc + 4, wrapping mod 2^32

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. On reset: pc=RESET_PC, buffer empty, drop_cnt=0, imem_req_valid=0, if_valid=0. if_instr, if_pc and if_pc_plus4 are forced to 0 whenever if_valid=0.
- Buffer: circular, DEPTH entries of {pc, instr, filled}.
  - An entry is allocated at request acceptance, recording the PC.
  - It is filled by the next non-dropped response.
  - Pointers wrap modulo DEPTH. count = allocated entries.
- Request: imem_req_valid = !reset && count<DEPTH && !redirect_valid.
  - Handshake = imem_req_valid && imem_req_ready: allocate at tail, pc <= pc+4 (wraps mod 2^32).
  - imem_req_addr = pc. It holds stable while valid && !ready, except on a redirect, which may withdraw or replace a pending request.
- Response: if drop_cnt>0, discard and decrement drop_cnt. Otherwise fill the oldest unfilled entry.
  - A response with no unfilled entry and drop_cnt=0 is a protocol violation: ignore it; a bench assertion flags it.
- Output: if_valid = head entry filled. Pop when if_valid && id_ready.
  - Back-to-back issue gives 1 instruction/cycle when memory responds at fixed latency and id_ready=1.
  - Minimum latency is request accept → if_valid one cycle after the response edge (response registered into the buffer).
- Full: count==DEPTH blocks requests. A pop and an accept in the same cycle are both allowed; count is unchanged.
- Redirect (one-cycle pulse, may be held):
  - pc <= {redirect_pc[31:2],2'b00}; buffer is flushed (count=0, if_valid=0 next cycle).
  - drop_cnt <= (unfilled allocated entries) + drop_cnt − (1 if a response arrives this cycle).
  - A response arriving in the redirect cycle is discarded.
  - A pop in the redirect cycle is ignored.
  - No request is issued in the redirect cycle; the first request to redirect_pc is issued the next cycle.
  - drop_cnt never exceeds DEPTH (width clog2(DEPTH)+1).
- New requests may issue while drop_cnt>0. In-order responses guarantee that old-path words are dropped before new-path words arrive.
- Reset mid-operation: all state clears immediately. Memory must also be reset; late responses after reset are not supported.

Decomposition:
- Shared package mips_pkg: RESET_PC default, INSTR_W=32, NOP=32'h0000_0000, opcode constants (RTYPE 000000, ORI 001101, ADDIU 001001, LW 100011, SW 101011, BEQ 000100, J 000010). The decoder and the bench share these constants.
- One sub-module, fetch_buffer: circular store with alloc(pc), fill(instr), pop, and flush returning the unfilled count. Top level holds the PC, request logic and drop_cnt.

Test Plan:
1. Reset release, memory ready always, 1-cycle response, id_ready=1 → requests at 0x3000, 0x3004, 0x3008…; if_valid from cycle 3; one instruction per cycle; if_pc_plus4 = if_pc+4.
2. id_ready=0 for 5 cycles → exactly DEPTH=2 allocations, imem_req_valid=0 while full; on id_ready=1, instructions emerge in PC order with no loss or duplication.
3. imem_req_ready low for 3 cycles with imem_req_valid high → imem_req_addr held at 0x3008; pc does not advance.
4. Redirect to 0x3103 with 2 requests outstanding → next request addr 0x3100; the 2 stale responses are discarded; first if_pc = 0x3100.
5. Redirect in the same cycle as a response and a pop → response dropped, pop ignored, if_valid=0 next cycle, drop_cnt = outstanding−1.
6. Redirect to 0xFFFF_FFFC → requests 0xFFFF_FFFC then 0x0000_0000; if_pc_plus4 for the first = 0x0000_0000.
